button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000, meaning the number of i_clk cycles a synchronized input must stay stable before its debounced level changes.
REQ-002 The block SHALL have parameter RPT_DELAY, default 50000000, meaning the i_clk cycles from the press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter RPT_PERIOD, default 10000000, meaning the i_clk cycles between successive auto-repeat pulses.
REQ-004 i_clk  input  1  system clock; all logic is on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_btn_incr  input  1  raw, asynchronous, bouncing increment pushbutton, high = pressed.
REQ-007 i_btn_decr  input  1  raw, asynchronous, bouncing decrement pushbutton, high = pressed.
REQ-008 i_btn_clr  input  1  raw, asynchronous, bouncing clear pushbutton, high = pressed.
REQ-009 o_incr  output  1  one-i_clk-cycle increment request pulse.
REQ-010 o_decr  output  1  one-i_clk-cycle decrement request pulse.
REQ-011 o_clr  output  1  one-i_clk-cycle clear request pulse.
REQ-012 o_held  output  3  debounced levels {clr, decr, incr}, for status LEDs.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each channel SHALL have its own debounce counter; the counter SHALL clear whenever the synchronized input equals the debounced level, and it SHALL increment otherwise.
REQ-015 The debounced level SHALL toggle, and the counter SHALL clear, in the cycle the counter reaches DEB_CYCLES-1, so a clean edge reaches o_held exactly DEB_CYCLES+2 cycles after it is applied.
REQ-016 A glitch shorter than DEB_CYCLES cycles SHALL NOT change o_held or produce any pulse.
REQ-017 The incr and decr channels SHALL each run a three-state FSM: IDLE, DELAY, REPEAT.
REQ-018 IDLE -> DELAY on the debounced rising edge; the output pulses high in the same cycle that o_held rises, and the repeat timer loads 0.
REQ-019 In DELAY, when the timer reaches RPT_DELAY-1, the output pulses for 1 cycle, the timer clears, and the FSM moves to REPEAT.
REQ-020 In REPEAT, when the timer reaches RPT_PERIOD-1, the output pulses for 1 cycle and the timer clears; this repeats while the button is held.
REQ-021 From DELAY or REPEAT, a debounced release SHALL return the FSM to IDLE with no pulse.
REQ-022 Contention: while debounced incr and decr are both high, o_incr and o_decr SHALL be held low, both FSMs SHALL be forced to IDLE, and o_clr SHALL pulse once on entry to that condition.
REQ-023 After contention, a press pulse SHALL be generated only by a new debounced rising edge; a button that stays held SHALL produce no pulse.
REQ-024 The clr channel SHALL have no auto-repeat; it pulses once per debounced rising edge.
REQ-025 o_clr SHALL be the OR of the clr-channel pulse and the contention pulse, and SHALL be 1 cycle wide even if both events fall in the same cycle.
REQ-026 All timers SHALL saturate-free clear as specified and SHALL never wrap mid-count; counter widths SHALL be sized from the parameters.
REQ-027 Outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-028 While i_rst_n is low, all synchronizers, debounced levels, counters, and FSMs SHALL be cleared (FSMs to IDLE), and o_incr, o_decr, o_clr, and o_held SHALL be 0.
REQ-029 If reset deasserts while a button is already held, the block SHALL treat it as a new press after debounce, producing one pulse at DEB_CYCLES+2 cycles.
REQ-030 Reset asserted mid-DELAY or mid-REPEAT SHALL abort the sequence immediately, with no trailing pulse.

Verification (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5)
REQ-031 Clean press of incr for 10 cycles -> o_held[0] rises at cycle 6, one o_incr pulse at cycle 6, no further pulses, o_held[0] falls 6 cycles after release.
REQ-032 Bouncing incr (toggle every 2 cycles for 12 cycles, then steady high) -> exactly one o_incr pulse, 6 cycles after the last toggle.
REQ-033 Hold decr for 60 cycles -> o_decr pulses at press, press+20, press+25, press+30 ... (8 total before release), none after release.
REQ-034 Press incr, then press decr while incr is held -> one o_incr pulse, then one o_clr pulse when decr debounces, no o_decr; release decr with incr still held -> no pulse.
REQ-035 Hold incr, assert i_rst_n low at press+22 for 3 cycles, then release reset -> no pulses during reset, all outputs 0, one new o_incr pulse 6 cycles after reset release.
REQ-036 Tap clr for 10 cycles -> exactly one o_clr pulse, o_held[2] high for 10 cycles.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - pushbutton synchronizer, debouncer and auto-repeat pulse generator
// Three channels {clr, decr, incr}; incr/decr auto-repeat, simultaneous incr+decr becomes a clear.
module button_conditioner #(
  parameter int DEB_CYCLES = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_incr,
  input  logic       i_btn_decr,
  input  logic       i_btn_clr,
  output logic       o_incr,
  output logic       o_decr,
  output logic       o_clr,
  output logic [2:0] o_held
);

  localparam int DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int TW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(RPT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [2:0]          btn_raw;
  logic [2:0]          sync_q1;
  logic [2:0]          sync_q2;
  logic [2:0]          held_q;
  logic [2:0]          held_d;
  logic [2:0][DW-1:0]  deb_cnt_q;
  logic [2:0][DW-1:0]  deb_cnt_d;
  logic [2:0]          rise;
  logic                cont_q;
  logic                cont_d;

  rpt_state_t [1:0]    state_q;
  rpt_state_t [1:0]    state_d;
  logic [1:0][TW-1:0]  tmr_q;
  logic [1:0][TW-1:0]  tmr_d;
  logic [1:0]          pulse_d;
  logic                clr_d;

  assign btn_raw = {i_btn_clr, i_btn_decr, i_btn_incr};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      held_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      held_q    <= held_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Counter only runs while the synchronized level disagrees with the debounced one.
  always_comb begin
    held_d    = held_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync_q2[i] == held_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        held_d[i]    = ~held_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  // Decisions use the next debounced level so pulses line up with o_held changing.
  assign rise   = held_d & ~held_q;
  assign cont_q = held_q[0] & held_q[1];
  assign cont_d = held_d[0] & held_d[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
      end
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    for (int i = 0; i < 2; i++) begin
      if (cont_d) begin
        state_d[i] = ST_IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              state_d[i] = ST_DELAY;
              tmr_d[i]   = '0;
            end
          end
          ST_DELAY: begin
            if (!held_d[i]) begin
              state_d[i] = ST_IDLE;
              tmr_d[i]   = '0;
            end else if (tmr_q[i] == DELAY_LAST) begin
              state_d[i] = ST_REPEAT;
              tmr_d[i]   = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + TW'(1);
            end
          end
          ST_REPEAT: begin
            if (!held_d[i]) begin
              state_d[i] = ST_IDLE;
              tmr_d[i]   = '0;
            end else if (tmr_q[i] == PERIOD_LAST) begin
              tmr_d[i] = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + TW'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (!cont_d) begin
        case (state_q[i])
          ST_IDLE:   pulse_d[i] = rise[i];
          ST_DELAY:  pulse_d[i] = held_d[i] && (tmr_q[i] == DELAY_LAST);
          ST_REPEAT: pulse_d[i] = held_d[i] && (tmr_q[i] == PERIOD_LAST);
          default:   pulse_d[i] = 1'b0;
        endcase
      end
    end
    clr_d = rise[2] | (cont_d & ~cont_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_incr <= 1'b0;
      o_decr <= 1'b0;
      o_clr  <= 1'b0;
    end else begin
      o_incr <= pulse_d[0];
      o_decr <= pulse_d[1];
      o_clr  <= clr_d;
    end
  end

  assign o_held = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and randomized checks of button_conditioner against a behavioural model
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_incr = 1'b0;
  logic       btn_decr = 1'b0;
  logic       btn_clr = 1'b0;
  logic       o_incr, o_decr, o_clr;
  logic [2:0] o_held;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit [2:0] pulse_at [MAXC];
  bit [2:0] held_at  [MAXC];

  // model state: sync stages, recent synchronized samples, debounced level, press timestamps
  bit [2:0] m_s1, m_s2, m_deb;
  bit [2:0] m_hist[$];
  bit [1:0] m_armed;
  int       m_press[2];

  button_conditioner #(
    .DEB_CYCLES(DEB),
    .RPT_DELAY (RDLY),
    .RPT_PERIOD(RPER)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_btn_incr(btn_incr),
    .i_btn_decr(btn_decr),
    .i_btn_clr (btn_clr),
    .o_incr    (o_incr),
    .o_decr    (o_decr),
    .o_clr     (o_clr),
    .o_held    (o_held)
  );

  always #5 clk = ~clk;

  task automatic model_step(output logic [5:0] exp_v);
    bit [2:0] deb_new, rise, pulses;
    bit       cont_old, cont_new, stable;
    int       e;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_armed = '0;
      m_hist.delete();
      exp_v = '0;
      return;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    deb_new = m_deb;
    for (int ch = 0; ch < 3; ch++) begin
      if (m_hist.size() == DEB) begin
        stable = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][ch] == m_deb[ch]) stable = 1'b0;
        if (stable) deb_new[ch] = ~m_deb[ch];
      end
    end
    m_s2 = m_s1;
    m_s1 = {btn_clr, btn_decr, btn_incr};
    rise     = deb_new & ~m_deb;
    cont_old = m_deb[0] & m_deb[1];
    cont_new = deb_new[0] & deb_new[1];
    pulses   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (cont_new || !deb_new[ch]) m_armed[ch] = 1'b0;
      else if (rise[ch]) begin
        m_armed[ch] = 1'b1;
        m_press[ch] = cyc;
      end
      if (m_armed[ch]) begin
        e = cyc - m_press[ch];
        if (e == 0 || e == RDLY || (e > RDLY && (e - RDLY) % RPER == 0)) pulses[ch] = 1'b1;
      end
    end
    pulses[2] = rise[2] | (cont_new & ~cont_old);
    m_deb = deb_new;
    exp_v = {deb_new, pulses};
  endtask

  always @(posedge clk) begin
    logic [5:0] exp_v, act_v;
    cyc++;
    model_step(exp_v);
    #1;
    act_v = {o_held, o_clr, o_decr, o_incr};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL model cycle %0d {held,clr,decr,incr} actual=%b expected=%b", cyc, act_v, exp_v);
    end
    if (cyc < MAXC) begin
      pulse_at[cyc] = {o_clr, o_decr, o_incr};
      held_at[cyc]  = o_held;
    end
  end

  task automatic expect_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(bit [2:0] v);
    {btn_clr, btn_decr, btn_incr} = v;
  endtask

  function automatic int count_pulses(int ch, int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (c > 0 && c < MAXC && pulse_at[c][ch]) n++;
    return n;
  endfunction

  function automatic int first_pulse(int ch, int a, int b);
    for (int c = a; c <= b; c++) if (c > 0 && c < MAXC && pulse_at[c][ch]) return c;
    return -1;
  endfunction

  function automatic int count_held(int ch, int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (c > 0 && c < MAXC && held_at[c][ch]) n++;
    return n;
  endfunction

  initial begin
    int t0;
    int offs [8] = '{6, 26, 31, 36, 41, 46, 51, 56};

    wait_cycles(4);
    expect_int("reset_outputs", int'({o_held, o_clr, o_decr, o_incr}), 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // clean 10-cycle incr press
    t0 = cyc; drive(3'b001); wait_cycles(10); drive(3'b000); wait_cycles(20);
    expect_int("clean_incr_pulse_at", first_pulse(0, t0, t0 + 30) - t0, 6);
    expect_int("clean_incr_pulse_count", count_pulses(0, t0, t0 + 30), 1);
    expect_int("clean_held_before_rise", int'(held_at[t0 + 5][0]), 0);
    expect_int("clean_held_at_rise", int'(held_at[t0 + 6][0]), 1);
    expect_int("clean_held_before_fall", int'(held_at[t0 + 15][0]), 1);
    expect_int("clean_held_after_fall", int'(held_at[t0 + 16][0]), 0);

    // bouncing incr then steady high
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? 3'b001 : 3'b000);
      wait_cycles(2);
    end
    drive(3'b001); wait_cycles(12); drive(3'b000); wait_cycles(20);
    expect_int("bounce_pulse_count", count_pulses(0, t0, t0 + 44), 1);
    expect_int("bounce_pulse_at", first_pulse(0, t0, t0 + 44) - t0, 18);

    // held decr auto-repeat
    t0 = cyc; drive(3'b010); wait_cycles(60); drive(3'b000); wait_cycles(20);
    expect_int("repeat_count_before_release", count_pulses(1, t0, t0 + 59), 8);
    for (int k = 0; k < 8; k++) expect_int($sformatf("repeat_pulse_%0d", k), int'(pulse_at[t0 + offs[k]][1]), 1);
    expect_int("repeat_none_after_held_falls", count_pulses(1, t0 + 66, t0 + 80), 0);
    expect_int("repeat_no_incr", count_pulses(0, t0, t0 + 80), 0);

    // contention
    t0 = cyc; drive(3'b001); wait_cycles(10); drive(3'b011); wait_cycles(20);
    drive(3'b001); wait_cycles(30); drive(3'b000); wait_cycles(20);
    expect_int("contend_incr_count", count_pulses(0, t0, t0 + 80), 1);
    expect_int("contend_incr_at", first_pulse(0, t0, t0 + 80) - t0, 6);
    expect_int("contend_clr_count", count_pulses(2, t0, t0 + 80), 1);
    expect_int("contend_clr_at", first_pulse(2, t0, t0 + 80) - t0, 16);
    expect_int("contend_decr_count", count_pulses(1, t0, t0 + 80), 0);
    expect_int("contend_held_both", int'(held_at[t0 + 16]), 3);

    // reset in the middle of a held press
    t0 = cyc; drive(3'b001); wait_cycles(28);
    rst_n = 1'b0;
    #1;
    expect_int("midreset_outputs", int'({o_held, o_clr, o_decr, o_incr}), 0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(9); drive(3'b000); wait_cycles(20);
    expect_int("midreset_count", count_pulses(0, t0, t0 + 60), 3);
    expect_int("midreset_during_reset", count_pulses(0, t0 + 29, t0 + 31), 0);
    expect_int("midreset_new_press", int'(pulse_at[t0 + 37][0]), 1);

    // clr tap
    t0 = cyc; drive(3'b100); wait_cycles(10); drive(3'b000); wait_cycles(20);
    expect_int("clr_count", count_pulses(2, t0, t0 + 30), 1);
    expect_int("clr_at", first_pulse(2, t0, t0 + 30) - t0, 6);
    expect_int("clr_held_width", count_held(2, t0, t0 + 30), 10);

    // randomized presses with bounce and occasional resets
    for (int ep = 0; ep < 80; ep++) begin
      int nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++) begin
        drive(3'($urandom_range(0, 7)));
        wait_cycles($urandom_range(1, 3));
      end
      drive(3'($urandom_range(0, 7)));
      wait_cycles($urandom_range(1, 60));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        wait_cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) begin
        drive(3'($urandom_range(0, 7)));
        wait_cycles($urandom_range(1, 3));
      end
      drive(3'b000);
      wait_cycles($urandom_range(0, 12));
    end
    wait_cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
